// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-control sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam int DRAIN_DEPTH_DEF = 3;
    localparam int CNT_W_DEF       = 16;

    // One bit per pipeline control line driven by pipe_ctrl.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_we;
        logic memwb_bubble;
    } ctrl_t;

    // Everything off: what the pipeline sees while in reset.
    localparam ctrl_t CTRL_NOP  = '0;
    // Free-running advance: every register loads, nothing squashed.
    localparam ctrl_t CTRL_DFLT = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                    idex_we: 1'b1, idex_bubble: 1'b0, exmem_we: 1'b1,
                                    memwb_we: 1'b1, memwb_bubble: 1'b0};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count on inc until every bit is set, then hold.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (inc && (cnt_q != '1))
            cnt_q <= cnt_q + W'(1);
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline-control sequencer: per-cycle register enables, flush/bubble
// selection, halt/drain FSM and performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DRAIN_DEPTH = DRAIN_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic             hlt_id,
    input  logic             dmem_req,
    input  logic             dmem_rdy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int DW = $clog2(DRAIN_DEPTH + 1);

    state_e        state_q;
    logic [DW-1:0] drain_q;
    logic          halted_q;
    logic          freeze;
    ctrl_t         ctrl;

    // A pending data-memory access freezes everything up to MEM; a halted
    // core no longer honours the memory handshake.
    assign freeze = dmem_req & ~dmem_rdy & (state_q != ST_HALT);

    // Control lines by priority: reset, freeze, then the state's own rules.
    always_comb begin
        ctrl = CTRL_DFLT;
        if (rst) begin
            ctrl = CTRL_NOP;
        end else if (freeze) begin
            ctrl.pc_we        = 1'b0;
            ctrl.ifid_we      = 1'b0;
            ctrl.idex_we      = 1'b0;
            ctrl.exmem_we     = 1'b0;
            ctrl.memwb_bubble = 1'b1;   // WB must not replay the held MEM op
            ctrl.ifid_flush   = (state_q == ST_DRAIN);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stall) begin
                        ctrl.pc_we       = 1'b0;
                        ctrl.ifid_we     = 1'b0;
                        ctrl.idex_bubble = 1'b1;
                    end else if (br_taken) begin
                        ctrl.ifid_flush  = 1'b1;
                    end else if (hlt_id) begin
                        ctrl.pc_we       = 1'b0;
                        ctrl.ifid_flush  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ctrl.pc_we      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                end
                ST_HALT: begin
                    ctrl.pc_we       = 1'b0;
                    ctrl.ifid_we     = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end
                default: ctrl = CTRL_DFLT;
            endcase
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign ifid_we      = ctrl.ifid_we;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_we      = ctrl.idex_we;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_we     = ctrl.exmem_we;
    assign memwb_we     = ctrl.memwb_we;
    assign memwb_bubble = ctrl.memwb_bubble;

    // Halt/drain FSM: HLT in ID lets the older stages retire, frozen cycles
    // do not count toward the drain, and only reset leaves HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!freeze && !stall && !br_taken && hlt_id) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DW'(DRAIN_DEPTH);
                    end
                end
                ST_DRAIN: begin
                    if (!freeze) begin
                        drain_q <= drain_q - DW'(1);
                        if (drain_q == DW'(1)) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign halted = halted_q;

    logic inc_cyc, inc_stall, inc_flush, inc_mem;

    // Counter events mirror exactly which action the control logic applied.
    assign inc_cyc   = (state_q != ST_HALT);
    assign inc_stall = (state_q == ST_RUN) & ~freeze & stall;
    assign inc_flush = (state_q == ST_RUN) & ~freeze & ~stall & br_taken;
    assign inc_mem   = freeze;

    sat_counter #(.W(CNT_W)) u_cyc   (.clk(clk), .rst(rst), .inc(inc_cyc),   .cnt(cyc_cnt));
    sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(inc_stall), .cnt(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(inc_flush), .cnt(flush_cnt));
    sat_counter #(.W(CNT_W)) u_mem   (.clk(clk), .rst(rst), .inc(inc_mem),   .cnt(memwait_cnt));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked
// against a behavioural model. A second instance with 4-bit counters
// exercises saturation on the same stimulus.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst, stall, br_taken, hlt_id, dmem_req, dmem_rdy;

    logic        a_pc, a_ifwe, a_iffl, a_idwe, a_idbub, a_exwe, a_mwwe, a_mwbub, a_halted;
    logic [15:0] a_cyc, a_stl, a_fls, a_mem;
    logic        b_pc, b_ifwe, b_iffl, b_idwe, b_idbub, b_exwe, b_mwwe, b_mwbub, b_halted;
    logic [3:0]  b_cyc, b_stl, b_fls, b_mem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16), .DRAIN_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .hlt_id(hlt_id),
        .dmem_req(dmem_req), .dmem_rdy(dmem_rdy),
        .pc_we(a_pc), .ifid_we(a_ifwe), .ifid_flush(a_iffl), .idex_we(a_idwe),
        .idex_bubble(a_idbub), .exmem_we(a_exwe), .memwb_we(a_mwwe), .memwb_bubble(a_mwbub),
        .halted(a_halted), .cyc_cnt(a_cyc), .stall_cnt(a_stl), .flush_cnt(a_fls),
        .memwait_cnt(a_mem)
    );

    pipe_ctrl #(.CNT_W(4), .DRAIN_DEPTH(3)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .hlt_id(hlt_id),
        .dmem_req(dmem_req), .dmem_rdy(dmem_rdy),
        .pc_we(b_pc), .ifid_we(b_ifwe), .ifid_flush(b_iffl), .idex_we(b_idwe),
        .idex_bubble(b_idbub), .exmem_we(b_exwe), .memwb_we(b_mwwe), .memwb_bubble(b_mwbub),
        .halted(b_halted), .cyc_cnt(b_cyc), .stall_cnt(b_stl), .flush_cnt(b_fls),
        .memwait_cnt(b_mem)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the core is running, draining (with a number of
    // unfrozen cycles still owed), or halted; event counts are plain ints.
    typedef enum {M_RUN, M_DRAIN, M_HALT} mode_e;
    mode_e m_mode   = M_RUN;
    int    m_owed   = 0;
    int    n_cyc = 0, n_stl = 0, n_fls = 0, n_mem = 0;

    function automatic int sat(input int v, input int w);
        int top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    // Expected control word {pc_we, ifid_we, ifid_flush, idex_we,
    // idex_bubble, exmem_we, memwb_we, memwb_bubble} for the current inputs.
    function automatic logic [7:0] exp_ctrl();
        logic frz = dmem_req & ~dmem_rdy & (m_mode != M_HALT);
        if (rst)                         return 8'b0000_0000;
        if (frz)                         return (m_mode == M_DRAIN) ? 8'b0010_0011 : 8'b0000_0011;
        if (m_mode == M_HALT)            return 8'b0001_1110;
        if (m_mode == M_DRAIN)           return 8'b0111_0110;
        if (stall)                       return 8'b0001_1110;
        if (br_taken)                    return 8'b1111_0110;
        if (hlt_id)                      return 8'b0111_0110;
        return 8'b1101_0110;
    endfunction

    task automatic model_clock();
        logic frz = dmem_req & ~dmem_rdy & (m_mode != M_HALT);
        if (rst) begin
            m_mode = M_RUN; m_owed = 0;
            n_cyc = 0; n_stl = 0; n_fls = 0; n_mem = 0;
            return;
        end
        if (m_mode != M_HALT) n_cyc++;
        if (frz) n_mem++;
        else if (m_mode == M_RUN) begin
            if (stall)          n_stl++;
            else if (br_taken)  n_fls++;
            else if (hlt_id)    begin m_mode = M_DRAIN; m_owed = 3; end
        end else if (m_mode == M_DRAIN) begin
            m_owed--;
            if (m_owed == 0) m_mode = M_HALT;
        end
    endtask

    // One cycle: drive at negedge, check control lines, clock, check state.
    task automatic step(input logic r, input logic s, input logic b, input logic h,
                        input logic q, input logic y);
        rst = r; stall = s; br_taken = b; hlt_id = h; dmem_req = q; dmem_rdy = y;
        #1;
        chk("ctrl16", {a_pc, a_ifwe, a_iffl, a_idwe, a_idbub, a_exwe, a_mwwe, a_mwbub}, exp_ctrl());
        chk("ctrl4",  {b_pc, b_ifwe, b_iffl, b_idwe, b_idbub, b_exwe, b_mwwe, b_mwbub}, exp_ctrl());
        @(posedge clk);
        model_clock();
        @(negedge clk);
        chk("halted16", a_halted, m_mode == M_HALT);
        chk("halted4",  b_halted, m_mode == M_HALT);
        chk("cyc16", a_cyc, sat(n_cyc, 16));
        chk("stl16", a_stl, sat(n_stl, 16));
        chk("fls16", a_fls, sat(n_fls, 16));
        chk("mem16", a_mem, sat(n_mem, 16));
        chk("cyc4",  b_cyc, sat(n_cyc, 4));
        chk("stl4",  b_stl, sat(n_stl, 4));
        chk("fls4",  b_fls, sat(n_fls, 4));
        chk("mem4",  b_mem, sat(n_mem, 4));
    endtask

    initial begin
        logic [15:0] cyc_hold;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; hlt_id = 1'b0;
        dmem_req = 1'b0; dmem_rdy = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0);

        // Idle run: ten free-running cycles.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
        chk("idle_cyc", a_cyc, 16'd10);
        chk("idle_stl", a_stl, 16'd0);

        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("stall2", a_stl, 16'd2);

        // Stall wins over branch; branch applies once the stall clears.
        step(0, 1, 1, 0, 0, 0);
        chk("stl_br_pc", a_pc, 1'b0);
        step(0, 0, 1, 0, 0, 0);
        chk("br_flush", a_fls, 16'd1);

        // Three frozen cycles with a stall pending, then completion.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("memwait3", a_mem, 16'd3);
        chk("frz_stl", a_stl, 16'd3);

        // HLT at t, freeze at t+2: halted visible from t+5.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_not_yet", a_halted, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        chk("halt_t5", a_halted, 1'b1);
        cyc_hold = a_cyc;
        step(0, 1, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0, 0);
        chk("halt_cyc_frozen", a_cyc, cyc_hold);
        step(1, 0, 0, 0, 0, 0);
        chk("halt_rst", a_halted, 1'b0);
        chk("halt_rst_cyc", a_cyc, 16'd0);

        // Reset while frozen mid-drain.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("rst_frz_mem", a_mem, 16'd0);
        step(0, 0, 1, 0, 0, 0);

        // Continuous stall: 4-bit counter pins at 15.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
        chk("sat_stl4", b_stl, 4'd15);
        chk("sat_stl16", a_stl, 16'd20);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
